roi_serial_driver: RTL

- Host-side master for the bit-serial ROI test harness; the counterpart of its shift-in/strobe/shift-out wrapper.
- Takes a parallel stimulus vector and serialises it MSB-first onto di.
- Strobes stb to apply the vector, re-applies it so the captured response belongs to this vector, then deserialises do into a parallel result.
- Sits in the fuzzer/minitest bench or in a hardware self-test wrapper in front of top.

---
 rtl/roi_serial_pkg.sv | 23 ++
 rtl/roi_serial_driver_if.sv | 17 +
 rtl/roi_serial_shreg.sv | 26 ++
 rtl/roi_serial_driver.sv | 167 ++++++++++++++++
 4 files changed

// File: rtl/roi_serial_pkg.sv
// Shared types and helpers for the bit-serial ROI harness driver.
// Holds the transaction state encoding, the counter-width helper and the latency limit.
package roi_serial_pkg;

  localparam int MAX_DO_LAT = 7;

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    APPLY,
    RELOAD,
    CAPTURE,
    WAIT_LAT,
    UNLOAD,
    DONE
  } state_t;

  // Bits needed to hold any count from 0 up to and including n.
  function automatic int cnt_width(input int n);
    return (n < 1) ? 1 : $clog2(n + 1);
  endfunction

endpackage

// File: rtl/roi_serial_driver_if.sv
// Host-side request/response bundle of the ROI serial driver.
// The host is the master; the driver is the slave.
interface roi_serial_driver_if #(
  parameter int DIN_N  = 256,
  parameter int DOUT_N = 256
);

  logic              start;
  logic [DIN_N-1:0]  vec_in;
  logic              busy;
  logic              done;
  logic [DOUT_N-1:0] vec_out;

  modport master (output start, vec_in, input busy, done, vec_out);
  modport slave  (input start, vec_in, output busy, done, vec_out);

endinterface

// File: rtl/roi_serial_shreg.sv
// Width-N shift register: parallel load, shift-left with serial-in at bit 0.
// The serial output is q[N-1]; the owner wires it wherever it is needed.
module roi_serial_shreg #(
  parameter int N = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic         shift,
  input  logic [N-1:0] d,
  input  logic         sin,
  output logic [N-1:0] q
);

  // NOTE: datapath flops are reset too, so no X can leak onto di or vec_out after reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      q <= '0;
    end else if (load) begin
      q <= d;
    end else if (shift) begin
      q <= (q << 1) | N'(sin);
    end
  end

endmodule

// File: rtl/roi_serial_driver.sv
// Host-side master for the bit-serial ROI harness: shifts a stimulus in MSB-first,
// strobes it twice so the captured response belongs to it, then shifts the response out.
module roi_serial_driver
  import roi_serial_pkg::*;
#(
  parameter int DIN_N  = 256,
  parameter int DOUT_N = 256,
  parameter int DO_LAT = 0
) (
  input  logic                clk,
  input  logic                rst,
  roi_serial_driver_if.slave  host,
  output logic                di,
  output logic                stb,
  input  logic                do_in
);

  localparam int MAX_N = (DIN_N > DOUT_N) ? DIN_N : DOUT_N;
  localparam int CNT_W = cnt_width((MAX_N > DO_LAT) ? MAX_N : DO_LAT);

  state_t            state;
  logic [CNT_W-1:0]  cnt;
  logic              busy_q;
  logic              done_q;
  logic [DOUT_N-1:0] vec_out_q;

  logic              accept;
  logic              piso_shift;
  logic              sipo_shift;
  logic [DIN_N-1:0]  piso_d;
  logic [DIN_N-1:0]  piso_q;
  logic              piso_msb;
  logic [DOUT_N-1:0] sipo_q;
  logic [DOUT_N-1:0] sipo_next;
  logic              piso_lower_unused;

  assign accept = (state == IDLE) && host.start;

  // The stimulus register rotates through itself, so after every full pass it holds
  // vec_q again and RELOAD can replay it without a second copy. It is loaded pre-rotated
  // by one because the first bit leaves on di directly from vec_in at the accept edge.
  assign piso_d     = (host.vec_in << 1) | DIN_N'(host.vec_in[DIN_N-1]);
  assign piso_msb   = piso_q[DIN_N-1];
  assign piso_shift = (((state == LOAD) || (state == RELOAD)) && (cnt != '0))
                    || (state == APPLY);
  assign piso_lower_unused = ^piso_q;

  assign sipo_shift = (state == UNLOAD);
  assign sipo_next  = (sipo_q << 1) | DOUT_N'(do_in);

  roi_serial_shreg #(.N(DIN_N)) u_piso (
    .clk   (clk),
    .rst   (rst),
    .load  (accept),
    .shift (piso_shift),
    .d     (piso_d),
    .sin   (piso_msb),
    .q     (piso_q)
  );

  roi_serial_shreg #(.N(DOUT_N)) u_sipo (
    .clk   (clk),
    .rst   (rst),
    .load  (1'b0),
    .shift (sipo_shift),
    .d     ('0),
    .sin   (do_in),
    .q     (sipo_q)
  );

  // Outputs are registered: each transition sets di/stb for the state being entered.
  // NOTE: sequential state uses non-blocking assignments only, so the defaults below
  // are simply overridden by later assignments in the same edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      cnt       <= '0;
      di        <= 1'b0;
      stb       <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      vec_out_q <= '0;
    end else begin
      di     <= 1'b0;
      stb    <= 1'b0;
      done_q <= 1'b0;

      unique case (state)
        IDLE: begin
          if (host.start) begin
            state  <= LOAD;
            cnt    <= CNT_W'(DIN_N - 1);
            busy_q <= 1'b1;
            di     <= host.vec_in[DIN_N-1];
          end
        end

        LOAD: begin
          if (cnt == '0) begin
            state <= APPLY;
            stb   <= 1'b1;
          end else begin
            cnt <= cnt - 1'b1;
            di  <= piso_msb;
          end
        end

        APPLY: begin
          state <= RELOAD;
          cnt   <= CNT_W'(DIN_N - 1);
          di    <= piso_msb;
        end

        RELOAD: begin
          if (cnt == '0) begin
            state <= CAPTURE;
            stb   <= 1'b1;
          end else begin
            cnt <= cnt - 1'b1;
            di  <= piso_msb;
          end
        end

        CAPTURE: begin
          if (DO_LAT != 0) begin
            state <= WAIT_LAT;
            cnt   <= CNT_W'(DO_LAT - 1);
          end else begin
            state <= UNLOAD;
            cnt   <= CNT_W'(DOUT_N - 1);
          end
        end

        WAIT_LAT: begin
          if (cnt == '0) begin
            state <= UNLOAD;
            cnt   <= CNT_W'(DOUT_N - 1);
          end else begin
            cnt <= cnt - 1'b1;
          end
        end

        UNLOAD: begin
          if (cnt == '0) begin
            state     <= DONE;
            done_q    <= 1'b1;
            vec_out_q <= sipo_next;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end

        DONE: begin
          state  <= IDLE;
          busy_q <= 1'b0;
        end

        default: state <= IDLE;
      endcase
    end
  end

  assign host.busy    = busy_q;
  assign host.done    = done_q;
  assign host.vec_out = vec_out_q;

endmodule
